// File: rtl/drive_pkg.sv
// Shared drive-mode types: vehicle state encoding and command byte bit positions.
// Also used by the autonomous-mode blocks, so keep the encodings stable.
package drive_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    IDLE   = 2'd1,
    START  = 2'd2,
    MOVING = 2'd3
  } drive_state_t;

  localparam int CMD_FWD   = 0;
  localparam int CMD_BACK  = 1;
  localparam int CMD_LEFT  = 2;
  localparam int CMD_RIGHT = 3;

endpackage

// File: rtl/cmd_tx_sched.sv
// Command byte scheduler: offers a byte on change, on keep-alive expiry or on power-up,
// and holds it stable on the valid/ready handshake until the UART takes it.
module cmd_tx_sched #(
  parameter int REFRESH_CYCLES = 10_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       link_up,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_data
);

  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_CYCLES);

  logic [RW-1:0] refresh_cnt;
  logic [7:0]    last_sent;
  logic          link_q;
  logic          announce_pend;
  logic          link_rise;
  logic          send_req;
  logic          offer;

  // Leaving OFF announces the vehicle even if the byte itself did not change.
  assign link_rise = link_up & ~link_q;
  assign send_req  = (cmd_byte != last_sent) | (refresh_cnt == REFRESH_TC) |
                     announce_pend | link_rise;
  assign offer     = ~cmd_valid & send_req;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cmd_valid     <= 1'b0;
      cmd_data      <= 8'h00;
      last_sent     <= 8'h00;
      refresh_cnt   <= '0;
      link_q        <= 1'b0;
      announce_pend <= 1'b0;
    end else begin
      link_q <= link_up;
      if (cmd_valid && cmd_ready) begin
        cmd_valid     <= 1'b0;
        last_sent     <= cmd_data;
        refresh_cnt   <= '0;
        announce_pend <= announce_pend | link_rise;
      end else begin
        if (refresh_cnt != REFRESH_TC)
          refresh_cnt <= refresh_cnt + RW'(1);
        announce_pend <= offer ? 1'b0 : (announce_pend | link_rise);
        if (offer) begin
          cmd_valid <= 1'b1;
          cmd_data  <= cmd_byte;
        end
      end
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-mode driving controller: power/start/move rules from the board switches,
// command byte generation towards the UART TX path, and the mileage counter.
//
// state  | meaning
// OFF    | vehicle powered down, waiting for a held power_on
// IDLE   | powered, engine idling, no gear engaged
// START  | clutch in with throttle, ready to pull away
// MOVING | driving forward or in reverse, mileage accumulating
module manual_drive_ctrl
  import drive_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int PWR_ON_CYCLES  = 100_000_000,
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int MILE_CYCLES    = 100_000_000,
  parameter int MILE_W         = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              power_on,
  input  logic              power_off,
  input  logic              throttle,
  input  logic              clutch,
  input  logic              brake,
  input  logic              reverse_sw,
  input  logic              turn_left,
  input  logic              turn_right,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [7:0]        cmd_data,
  output logic [1:0]        drive_state,
  output logic [MILE_W-1:0] mileage
);

  localparam int PW = $clog2(PWR_ON_CYCLES + 1);
  localparam int MW = $clog2(MILE_CYCLES + 1);

  drive_state_t  state_q;
  drive_state_t  state_d;
  logic [PW-1:0] pwr_cnt;
  logic [MW-1:0] mile_cnt;
  logic          reverse_q;
  logic          pwr_tc;
  logic          rev_violation;
  logic [7:0]    cmd_byte;

  assign pwr_tc        = power_on && (pwr_cnt == PW'(PWR_ON_CYCLES - 1));
  // Shifting gear while driving without the clutch stalls the engine.
  assign rev_violation = (state_q == MOVING) && !clutch && (reverse_sw != reverse_q);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state_q <= OFF;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (power_off)                     state_d = OFF;
    else if (rev_violation)            state_d = OFF;
    else if (brake && state_q != OFF)  state_d = IDLE;
    else begin
      case (state_q)
        OFF:     if (pwr_tc) state_d = IDLE;
        IDLE:    if (throttle && clutch) state_d = START;
                 else if (throttle)      state_d = OFF;
        START:   if (throttle && !clutch) state_d = MOVING;
        MOVING:  if (clutch || !throttle) state_d = START;
        default: state_d = OFF;
      endcase
    end
  end

  always_comb begin
    cmd_byte            = 8'h00;
    cmd_byte[CMD_FWD]   = (state_q == MOVING) && !reverse_sw;
    cmd_byte[CMD_BACK]  = (state_q == MOVING) && reverse_sw;
    cmd_byte[CMD_LEFT]  = turn_left && !turn_right && (state_q != OFF);
    cmd_byte[CMD_RIGHT] = turn_right && !turn_left && (state_q != OFF);
    drive_state         = state_q;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      reverse_q <= 1'b0;
      pwr_cnt   <= '0;
      mile_cnt  <= '0;
      mileage   <= '0;
    end else begin
      reverse_q <= reverse_sw;
      if (state_q == OFF && power_on && !power_off && !pwr_tc)
        pwr_cnt <= pwr_cnt + PW'(1);
      else
        pwr_cnt <= '0;
      // Partial distance is kept across stops so short hops still add up.
      if (state_q == MOVING) begin
        if (mile_cnt == MW'(MILE_CYCLES - 1)) begin
          mile_cnt <= '0;
          if (mileage != '1) mileage <= mileage + MILE_W'(1);
        end else begin
          mile_cnt <= mile_cnt + MW'(1);
        end
      end
    end
  end

  cmd_tx_sched #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_cmd_tx_sched (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .link_up   (state_q != OFF),
    .cmd_byte  (cmd_byte),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data)
  );

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Bench for manual_drive_ctrl: a rule-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_manual_drive_ctrl;

  localparam int PWR = 8;
  localparam int REF = 32;
  localparam int MIL = 4;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        power_on, power_off, throttle, clutch, brake, reverse_sw;
  logic        turn_left, turn_right, cmd_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic [1:0]  drive_state;
  logic [15:0] mileage;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  manual_drive_ctrl #(
    .CLK_HZ(100_000_000), .PWR_ON_CYCLES(PWR), .REFRESH_CYCLES(REF),
    .MILE_CYCLES(MIL), .MILE_W(16)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .power_on(power_on), .power_off(power_off),
    .throttle(throttle), .clutch(clutch), .brake(brake), .reverse_sw(reverse_sw),
    .turn_left(turn_left), .turn_right(turn_right), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .drive_state(drive_state),
    .mileage(mileage)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Reference model: vehicle rules and transmit rules evaluated on each rising edge.
  int          m_state, m_pwr, m_mc, m_ref, m_nxt;
  int          m_mileage;
  bit          m_rev, m_valid, m_pend, m_link, m_rise;
  logic [7:0]  m_data, m_last, m_b;

  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_pwr = 0; m_mc = 0; m_ref = 0; m_mileage = 0;
      m_rev = 0; m_valid = 0; m_pend = 0; m_link = 0;
      m_data = 8'h00; m_last = 8'h00;
    end else begin
      m_b = 8'h00;
      if (m_state == 3) m_b = reverse_sw ? 8'd2 : 8'd1;
      if (m_state != 0 && turn_left != turn_right) m_b = m_b + (turn_left ? 8'd4 : 8'd8);

      m_nxt = m_state;
      if (power_off) m_nxt = 0;
      else if (m_state == 3 && !clutch && reverse_sw != m_rev) m_nxt = 0;
      else if (brake && m_state != 0) m_nxt = 1;
      else if (m_state == 0 && power_on && m_pwr == PWR - 1) m_nxt = 1;
      else if (m_state == 1 && throttle) m_nxt = clutch ? 2 : 0;
      else if (m_state == 2 && throttle && !clutch) m_nxt = 3;
      else if (m_state == 3 && (clutch || !throttle)) m_nxt = 2;

      m_pwr = (m_state == 0 && m_nxt == 0 && power_on && !power_off) ? m_pwr + 1 : 0;

      if (m_state == 3) begin
        m_mc = m_mc + 1;
        if (m_mc == MIL) begin
          m_mc = 0;
          if (m_mileage < 65535) m_mileage = m_mileage + 1;
        end
      end

      m_rise = (m_state != 0) && !m_link;
      if (m_rise) m_pend = 1;
      if (m_valid && cmd_ready) begin
        m_valid = 0; m_last = m_data; m_ref = 0;
      end else begin
        if (!m_valid && (m_b != m_last || m_ref == REF || m_pend)) begin
          m_valid = 1; m_data = m_b; m_pend = 0;
        end
        if (m_ref < REF) m_ref = m_ref + 1;
      end

      m_link  = (m_state != 0);
      m_rev   = reverse_sw;
      m_state = m_nxt;
    end
  end

  always @(negedge sys_clk) begin
    if (cmp_en && rst) begin
      check("model_state", drive_state, m_state);
      check("model_valid", cmd_valid, m_valid);
      check("model_data", cmd_data, m_data);
      check("model_mileage", mileage, m_mileage);
    end
  end

  int n_ka, last_i, first_d;
  bit found;

  task automatic power_up();
    power_on = 1'b1;
    tick(PWR);
    check("powerup_state", drive_state, 2'd1);
    power_on = 1'b0;
  endtask

  initial begin
    rst = 1'b0; power_on = 0; power_off = 0; throttle = 0; clutch = 0; brake = 0;
    reverse_sw = 0; turn_left = 0; turn_right = 0; cmd_ready = 1'b1;
    tick(3);
    check("reset_state", drive_state, 2'd0);
    check("reset_valid", cmd_valid, 1'b0);
    check("reset_mileage", mileage, 16'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Power-up: 7 cycles is not enough, 8 is.
    power_on = 1'b1; tick(7); power_on = 1'b0; tick(2);
    check("short_hold_off", drive_state, 2'd0);
    power_up();
    tick(1);
    check("announce_valid", cmd_valid, 1'b1);
    check("announce_data", cmd_data, 8'h00);

    // Start and go.
    throttle = 1; clutch = 1; tick(1);
    check("start_state", drive_state, 2'd2);
    clutch = 0; tick(1);
    check("moving_state", drive_state, 2'd3);
    tick(1);
    check("fwd_data", cmd_data, 8'h01);
    tick(7);
    check("mileage_8cyc", mileage, 16'd2);

    // Keep-alive: no input change, repeats every 34 cycles with ready high.
    n_ka = 0; last_i = -1; first_d = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (cmd_valid) begin
        n_ka++;
        check("keepalive_data", cmd_data, 8'h01);
        if (last_i >= 0) check("keepalive_gap", i - last_i, 34);
        last_i = i;
      end
    end
    check("keepalive_count", n_ka, 2);

    // Both turn switches: neither turn bit.
    turn_left = 1; turn_right = 1; n_ka = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (cmd_valid) begin
        n_ka++;
        check("both_turns_data", cmd_data, 8'h01);
      end
    end
    check("both_turns_count", n_ka, 1);
    turn_left = 0; turn_right = 0;

    // Reverse toggled without clutch while moving.
    reverse_sw = 1; tick(1);
    check("violation_state", drive_state, 2'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (cmd_valid && cmd_data == 8'h00) found = 1;
    end
    check("violation_byte_00", found, 1'b1);
    throttle = 0; reverse_sw = 0;

    // Brake back to IDLE, then power_off.
    power_up();
    throttle = 1; clutch = 1; tick(1);
    check("start2_state", drive_state, 2'd2);
    brake = 1; tick(1);
    check("brake_state", drive_state, 2'd1);
    brake = 0; throttle = 0; clutch = 0; power_off = 1; tick(1);
    check("power_off_state", drive_state, 2'd0);
    check("power_off_mileage", mileage, m_mileage);
    power_off = 0;

    // Stall: throttle without clutch in IDLE.
    power_up();
    throttle = 1; tick(1);
    check("stall_state", drive_state, 2'd0);
    throttle = 0;

    // Handshake: ready low holds 8'h05 for 50 cycles.
    power_up();
    throttle = 1; clutch = 1; tick(1);
    clutch = 0; tick(2);
    check("hs_pre_data", cmd_data, 8'h01);
    tick(1);
    cmd_ready = 0; turn_left = 1; tick(1);
    check("hs_valid", cmd_valid, 1'b1);
    check("hs_data", cmd_data, 8'h05);
    for (int i = 0; i < 50; i++) begin
      if (i == 25) turn_left = 0;
      tick(1);
      check("hs_hold_valid", cmd_valid, 1'b1);
      check("hs_hold_data", cmd_data, 8'h05);
    end
    cmd_ready = 1; tick(1);
    check("hs_gap", cmd_valid, 1'b0);
    tick(1);
    check("hs_reoffer_valid", cmd_valid, 1'b1);
    check("hs_reoffer_data", cmd_data, 8'h01);
    cmd_ready = 0;
    tick(1);
    check("rst_pre_state", drive_state, 2'd3);

    // Asynchronous reset mid-handshake.
    #2 rst = 1'b0;
    #1;
    check("rst_async_state", drive_state, 2'd0);
    check("rst_async_valid", cmd_valid, 1'b0);
    check("rst_async_data", cmd_data, 8'h00);
    check("rst_async_mileage", mileage, 16'd0);
    tick(1);
    rst = 1'b1; cmd_ready = 1; throttle = 0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
